// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the sub-word memory responder.
package mem_resp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;

endpackage

// File: rtl/mem_subword_responder_if.sv
// Request/response and word-memory bus of the sub-word responder.
// master = CPU side plus memory model, slave = responder.
interface mem_subword_responder_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wr, mem_wdata
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/lane_merge.sv
// Little-endian lane logic: merges sub-word store data into the captured
// word and extracts/extends load data. Size 11 behaves as a word access.
module lane_merge
  import mem_resp_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        uns,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] merged,
  output logic [31:0] load_val
);
  logic [4:0]  byte_pos;
  logic [4:0]  half_pos;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_pos = {addr_lo, 3'b000};
  assign half_pos = {addr_lo[1], 4'b0000};

  // Lane select, merge and extension; halfword lane comes from addr[1] only.
  always_comb begin
    merged   = new_data;
    load_val = old_word;
    byte_sel = old_word[byte_pos +: 8];
    half_sel = old_word[half_pos +: 16];
    case (size)
      SIZE_BYTE: begin
        merged                 = old_word;
        merged[byte_pos +: 8]  = new_data[7:0];
        load_val               = {{24{byte_sel[7] & ~uns}}, byte_sel};
      end
      SIZE_HALF: begin
        merged                 = old_word;
        merged[half_pos +: 16] = new_data[15:0];
        load_val               = {{16{half_sel[15] & ~uns}}, half_sel};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_subword_responder.sv
// Responder turning byte/half/word CPU accesses into aligned word memory
// transactions (read-modify-write for sub-word stores).
// Optional macro MEM_RESP_ALIGN_CHECK_EN: misaligned or reserved-size
// requests are answered with rsp_err=1 and touch no memory.
module mem_subword_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic                    clk,
  input logic                    reset,
  mem_subword_responder_if.slave bus
);
  state_t            state, state_nx;
  logic              wr_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, data_q;
  logic              accept, in_err, is_word;
  logic [31:0]       merged, load_val;

  assign accept  = (state == IDLE) && bus.req_valid;
  assign is_word = (bus.req_size != SIZE_BYTE) && (bus.req_size != SIZE_HALF);

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign in_err = (bus.req_size == 2'b11)
               || ((bus.req_size == SIZE_HALF) && bus.req_addr[0])
               || ((bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
  assign in_err = 1'b0;
`endif

  lane_merge u_lane (
    .size     (size_q),
    .addr_lo  (addr_q[1:0]),
    .uns      (uns_q),
    .old_word (data_q),
    .new_data (wdata_q),
    .merged   (merged),
    .load_val (load_val)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Request latch on acceptance; data register captures memory in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SIZE_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      if (accept) begin
        wr_q    <= bus.req_wr;
        uns_q   <= bus.req_unsigned;
        err_q   <= in_err;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == WAIT) data_q <= bus.mem_rdata;
    end
  end

  // Next state and state-decoded outputs; mem_wr is killed by reset at once.
  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (in_err)                    state_nx = RESP;
          else if (bus.req_wr && is_word) state_nx = WRITE;
          else                           state_nx = READ;
        end
      end
      READ:  state_nx = WAIT;
      WAIT:  state_nx = wr_q ? WRITE : RESP;
      WRITE: begin
        bus.mem_wr    = ~reset;
        bus.mem_wdata = merged;
        state_nx      = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (!wr_q && !err_q) bus.rsp_rdata = load_val;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign bus.rsp_err = (state == RESP) && err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_subword_responder.sv
// Directed bench for mem_subword_responder with a word memory model.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_mem_subword_responder;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  mem_subword_responder_if #(.ADDR_W(32)) bus ();

  mem_subword_responder #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous word memory, 64 words, with a preload port.
  logic [31:0] mem [64];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;
  always @(posedge clk) begin
    if (pl_en)           mem[pl_idx] <= pl_data;
    else if (bus.mem_wr) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[7:2]];
  end

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Presents a request at the current falling edge.
  task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
    n_checks++; if (bus.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus.rsp_rdata); end
    n_checks++; if (bus.mem_wr !== 1'b0) begin n_err++; $display("FAIL reset_mem_wr: got %b want 0", bus.mem_wr); end
    n_checks++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
    reset = 1'b0;
  endtask

  task automatic test_word_store_load;
    @(negedge clk); issue(1'b1, 2'b00, 1'b0, 32'h40, 32'hDEADBEEF);
    @(negedge clk); bus.req_valid = 1'b0;                       // +1 WRITE
    n_checks++; if (bus.mem_wr !== 1'b1) begin n_err++; $display("FAIL wst_mem_wr: got %b want 1", bus.mem_wr); end
    n_checks++; if (bus.mem_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wst_wdata: got %h want deadbeef", bus.mem_wdata); end
    n_checks++; if (bus.mem_addr !== 32'h40) begin n_err++; $display("FAIL wst_addr: got %h want 40", bus.mem_addr); end
    n_checks++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL wst_busy: got %b want 0", bus.req_ready); end
    @(negedge clk);                                              // +2 RESP
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL wst_rsp: got %b want 1", bus.rsp_valid); end
    n_checks++; if (bus.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL wst_rdata: got %h want 0", bus.rsp_rdata); end
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL wst_ready: got %b want 1", bus.req_ready); end
    n_checks++; if (mem[16] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wst_mem: got %h want deadbeef", mem[16]); end
    issue(1'b0, 2'b00, 1'b0, 32'h40, 32'h0);
    @(negedge clk); bus.req_valid = 1'b0;                       // +1 READ
    n_checks++; if (bus.mem_wr !== 1'b0) begin n_err++; $display("FAIL wld_mem_wr: got %b want 0", bus.mem_wr); end
    @(negedge clk);                                              // +2 WAIT
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL wld_early: got %b want 0", bus.rsp_valid); end
    @(negedge clk);                                              // +3 RESP
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL wld_rsp: got %b want 1", bus.rsp_valid); end
    n_checks++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wld_rdata: got %h want deadbeef", bus.rsp_rdata); end
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL wld_err: got %b want 0", bus.rsp_err); end
  endtask

  task automatic test_byte_store;
    preload(6'd16, 32'h11223344);
    @(negedge clk); issue(1'b1, 2'b01, 1'b0, 32'h42, 32'h5555_55AA);
    @(negedge clk); bus.req_valid = 1'b0;                       // READ
    @(negedge clk);                                              // WAIT
    n_checks++; if (bus.mem_wr !== 1'b0) begin n_err++; $display("FAIL bst_nowr: got %b want 0", bus.mem_wr); end
    @(negedge clk);                                              // +3 WRITE
    n_checks++; if (bus.mem_wr !== 1'b1) begin n_err++; $display("FAIL bst_mem_wr: got %b want 1", bus.mem_wr); end
    n_checks++; if (bus.mem_wdata !== 32'h11AA3344) begin n_err++; $display("FAIL bst_wdata: got %h want 11aa3344", bus.mem_wdata); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL bst_early: got %b want 0", bus.rsp_valid); end
    @(negedge clk);                                              // +4 RESP
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL bst_rsp: got %b want 1", bus.rsp_valid); end
    n_checks++; if (mem[16] !== 32'h11AA3344) begin n_err++; $display("FAIL bst_mem: got %h want 11aa3344", mem[16]); end
  endtask

  task automatic test_load_extend;
    logic [31:0] la [6] = '{32'h43, 32'h43, 32'h40, 32'h42, 32'h42, 32'h41};
    logic [1:0]  ls [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
    logic        lu [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] le [6] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01,
                            32'hFFFF80FF, 32'h000000FF, 32'h0000007F};
    preload(6'd16, 32'h80FF7F01);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); issue(1'b0, ls[i], lu[i], la[i], 32'h0);
      @(negedge clk); bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== le[i]) begin
        n_err++; $display("FAIL load_ext[%0d]: got v=%b %h want v=1 %h", i, bus.rsp_valid, bus.rsp_rdata, le[i]);
      end
    end
  endtask

  task automatic test_half_misaligned;
    preload(6'd16, 32'hCAFEBABE);
    @(negedge clk); issue(1'b1, 2'b10, 1'b0, 32'h41, 32'hFFFF1234);
    @(negedge clk); bus.req_valid = 1'b0;
`ifdef MEM_RESP_ALIGN_CHECK_EN
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1) begin n_err++; $display("FAIL hmis_err: got v=%b e=%b want 1 1", bus.rsp_valid, bus.rsp_err); end
    n_checks++; if (bus.mem_wr !== 1'b0) begin n_err++; $display("FAIL hmis_nowr: got %b want 0", bus.mem_wr); end
    @(negedge clk);
    n_checks++; if (mem[16] !== 32'hCAFEBABE) begin n_err++; $display("FAIL hmis_mem: got %h want cafebabe", mem[16]); end
`else
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus.mem_wr !== 1'b1 || bus.mem_wdata !== 32'hCAFE1234) begin n_err++; $display("FAIL hmis_wdata: got wr=%b %h want 1 cafe1234", bus.mem_wr, bus.mem_wdata); end
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL hmis_rsp: got v=%b e=%b want 1 0", bus.rsp_valid, bus.rsp_err); end
    n_checks++; if (mem[16] !== 32'hCAFE1234) begin n_err++; $display("FAIL hmis_mem: got %h want cafe1234", mem[16]); end
`endif
  endtask

  task automatic test_reset_in_write;
    preload(6'd18, 32'h11223344);
    @(negedge clk); issue(1'b1, 2'b01, 1'b0, 32'h49, 32'h99);
    @(negedge clk); bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);                                              // WRITE
    n_checks++; if (bus.mem_wr !== 1'b1) begin n_err++; $display("FAIL rstw_pre: got %b want 1", bus.mem_wr); end
    reset = 1'b1;
    #1;
    n_checks++; if (bus.mem_wr !== 1'b0) begin n_err++; $display("FAIL rstw_gate: got %b want 0", bus.mem_wr); end
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstw_idle: got rdy=%b v=%b want 1 0", bus.req_ready, bus.rsp_valid); end
    n_checks++; if (mem[18] !== 32'h11223344) begin n_err++; $display("FAIL rstw_mem: got %h want 11223344", mem[18]); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstw_norsp: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_back_to_back;
    preload(6'd16, 32'hA5A5_0001);
    preload(6'd17, 32'h5A5A_0002);
    @(negedge clk); issue(1'b0, 2'b00, 1'b0, 32'h40, 32'h0);
    @(negedge clk); bus.req_addr = 32'h44;                      // ignored while busy
    @(negedge clk);
    @(negedge clk);                                              // +3 RESP
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hA5A50001) begin n_err++; $display("FAIL b2b_first: got v=%b %h want 1 a5a50001", bus.rsp_valid, bus.rsp_rdata); end
    @(negedge clk);                                              // IDLE, accepts
    n_checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got rdy=%b v=%b want 1 0", bus.req_ready, bus.rsp_valid); end
    @(negedge clk); bus.req_valid = 1'b0;
    n_checks++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_taken: got %b want 0", bus.req_ready); end
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_early: got %b want 0", bus.rsp_valid); end
    @(negedge clk);                                              // 4 after first RESP
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h5A5A0002) begin n_err++; $display("FAIL b2b_second: got v=%b %h want 1 5a5a0002", bus.rsp_valid, bus.rsp_rdata); end
  endtask

  initial begin
    reset = 1'b1;
    pl_en = 1'b0; pl_idx = '0; pl_data = '0;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_load_extend();
    test_half_misaligned();
    test_reset_in_write();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
